pe_col_sched: RTL and testbench

PE_COL_SCHED -- requirements
Module: pe_col_sched

---
 rtl/pe_col_sched.sv | 96 +++++++++
 tb/tb_pe_col_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_sched.sv
// pe_col_sched: sequences weight preload, skewed activation feed and result capture for one systolic PE column.
// Weights go in deepest row first; each activation row is delayed one extra cycle per row depth.
module pe_col_sched #(
  parameter int ROWS = 9,
  parameter int LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [7:0]          i_n_vec,
  input  logic                i_w_valid,
  input  logic [7:0]          i_w_data,
  output logic                o_w_ready,
  input  logic                i_a_valid,
  input  logic [ROWS*8-1:0]   i_a_data,
  output logic                o_a_ready,
  output logic [31:0]         o_north_data,
  output logic [ROWS*9-1:0]   o_west_data,
  input  logic [31:0]         i_south_data,
  output logic                o_res_valid,
  output logic [31:0]         o_res_data,
  output logic                o_busy,
  output logic                o_done
);
  localparam int WW = $clog2(ROWS + 1);
  localparam int PL = ROWS + LAT;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t state, state_nx;
  logic [7:0] n_vec, v_cnt, r_cnt;
  logic [WW-1:0] w_cnt;
  logic [ROWS-1:0] sk_v;
  logic [PL-1:0] res_pipe;
  logic beat, acc, w_last;

  assign o_w_ready = state == LOAD_W;
  assign o_a_ready = state == STREAM && v_cnt != n_vec;
  assign beat = i_w_valid && o_w_ready;
  assign acc = i_a_valid && o_a_ready;
  assign w_last = w_cnt == WW'(ROWS - 1);
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_res_valid = res_pipe[PL-1];
  assign o_res_data = o_res_valid ? i_south_data : 32'd0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? LOAD_W : IDLE;
      LOAD_W:  state_nx = beat && w_last ? (n_vec == 8'd0 ? DONE : STREAM) : LOAD_W;
      STREAM:  state_nx = acc && v_cnt + 8'd1 == n_vec ? DRAIN : STREAM;
      DRAIN:   state_nx = o_res_valid && r_cnt + 8'd1 == n_vec ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_vec <= '0;
      v_cnt <= '0;
      r_cnt <= '0;
      w_cnt <= '0;
      sk_v <= '0;
      res_pipe <= '0;
      o_north_data <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        n_vec <= i_n_vec;
        v_cnt <= '0;
        r_cnt <= '0;
        w_cnt <= '0;
      end
      if (beat) w_cnt <= w_cnt + WW'(1);
      if (acc) v_cnt <= v_cnt + 8'd1;
      if (o_res_valid) r_cnt <= r_cnt + 8'd1;
      o_north_data <= beat ? {24'd0, i_w_data} : (state == LOAD_W ? o_north_data : 32'd0);
      sk_v <= (sk_v << 1) | ROWS'(acc);
      res_pipe <= (res_pipe << 1) | PL'(acc);
    end
  end

  // row g keeps only its own byte, delayed g+1 cycles; empty slots shift in zeros
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    localparam int CW = (g + 1) * 8;
    logic [CW-1:0] ch;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) ch <= '0;
      else ch <= (ch << 8) | CW'(acc ? i_a_data[g*8 +: 8] : 8'd0);
    assign o_west_data[(ROWS-g)*9-1 -: 9] = {sk_v[g], ch[CW-1 -: 8]};
  end
endmodule

// File: tb/tb_pe_col_sched.sv
// tb_pe_col_sched: scoreboard bench for pe_col_sched with an ideal PE column model driving the south bus.
module tb_pe_col_sched;
  localparam int ROWS = 3, LAT = 2, PL = ROWS + LAT;

  logic clk = 0, rst_n = 0, start = 0, w_valid = 0, a_valid = 0;
  logic [7:0] n_vec = 0, w_data = 0;
  logic [ROWS*8-1:0] a_data = 0;
  logic [31:0] south = 0;
  logic w_ready, a_ready, res_valid, busy, done;
  logic [31:0] north, res_data;
  logic [ROWS*9-1:0] west;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int w_m [ROWS];
  int seen [ROWS];
  logic [ROWS*9-1:0] hist [PL] = '{default: '0};
  typedef struct {int data; int at;} exp_t;
  exp_t sb [$];
  logic [ROWS*9-1:0] exp_west [int];
  logic [ROWS*8:0] stim [$];
  int res_at [$];
  int res_val [$];
  int n_res, done_at;

  pe_col_sched #(.ROWS(ROWS), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_n_vec(n_vec),
    .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(w_ready),
    .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready),
    .o_north_data(north), .o_west_data(west), .i_south_data(south),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ideal column: row r's product reaches the south bus LAT+(ROWS-1-r) cycles after its west input
  always @(posedge clk) begin
    #1;
    for (int k = PL - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = west;
    south = 0;
    for (int r = 0; r < ROWS; r++)
      if (hist[PL-1-r][(ROWS-r)*9-1])
        south += 32'(w_m[r]) * 32'(hist[PL-1-r][(ROWS-r)*9-2 -: 8]);
  end

  function automatic logic [ROWS*8:0] vec(input int a0, a1, a2);
    return {1'b1, 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic start_job(input int n);
    @(negedge clk); start = 1; n_vec = 8'(n);
    @(negedge clk); start = 0;
  endtask

  task automatic load_w(input int b0, b1, b2);
    int b [ROWS];
    b = '{b0, b1, b2};
    for (int k = 0; k < ROWS; k++) begin
      w_valid = 1; w_data = 8'(b[k]); w_m[ROWS-1-k] = b[k];
      @(negedge clk); seen[k] = int'(north);
    end
    w_valid = 0;
  endtask

  task automatic run_stream(input string tag, input int budget);
    int i, sum, k;
    exp_t e;
    logic [ROWS*8:0] s;
    logic [ROWS*9-1:0] tmp, want;
    i = 0; n_res = 0; done_at = -1;
    res_at.delete(); res_val.delete(); exp_west.delete();
    for (int c = 0; c < budget && done_at < 0; c++) begin
      want = exp_west.exists(cyc) ? exp_west[cyc] : '0;
      n_cmp++;
      if (west !== want) begin
        n_bad++; $display("FAIL %s west cyc %0d: got %h want %h", tag, cyc, west, want);
      end
      if (res_valid === 1'b1) begin
        n_res++; n_cmp++;
        res_at.push_back(cyc); res_val.push_back(int'(res_data));
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL %s extra result %0d cyc %0d", tag, res_data, cyc);
        end else begin
          e = sb.pop_front();
          if (res_data !== 32'(e.data) || cyc != e.at) begin
            n_bad++;
            $display("FAIL %s result: got %0d at cyc %0d want %0d at cyc %0d", tag, res_data, cyc, e.data, e.at);
          end
        end
      end
      if (done === 1'b1) done_at = cyc;
      a_valid = 0;
      if (i < stim.size() && a_ready === 1'b1) begin
        s = stim[i++];
        a_valid = s[ROWS*8]; a_data = s[ROWS*8-1:0];
        if (s[ROWS*8]) begin
          sum = 0;
          for (int r = 0; r < ROWS; r++) sum += w_m[r] * int'(s[r*8 +: 8]);
          e.data = sum; e.at = cyc + PL; sb.push_back(e);
          for (int r = 0; r < ROWS; r++) begin
            k = cyc + r + 1;
            tmp = exp_west.exists(k) ? exp_west[k] : '0;
            tmp[(ROWS-r)*9-1 -: 9] = {1'b1, s[r*8 +: 8]};
            exp_west[k] = tmp;
          end
        end
      end
      @(negedge clk);
    end
    a_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({w_ready, a_ready, res_valid, busy, done} !== 5'b0) begin
      n_bad++; $display("FAIL reset flags: got %b want 00000", {w_ready, a_ready, res_valid, busy, done});
    end
    n_cmp++;
    if (north !== 32'd0) begin n_bad++; $display("FAIL reset north: got %h want 0", north); end
    n_cmp++;
    if (west !== '0) begin n_bad++; $display("FAIL reset west: got %h want 0", west); end
    n_cmp++;
    if (res_data !== 32'd0) begin n_bad++; $display("FAIL reset res_data: got %h want 0", res_data); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single(input string tag);
    start_job(1);
    n_cmp++;
    if (busy !== 1'b1 || w_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s load entry: busy %b w_ready %b want 1 1", tag, busy, w_ready);
    end
    load_w(3, 2, 1);
    for (int k = 0; k < ROWS; k++) begin
      n_cmp++;
      if (seen[k] != 3 - k) begin n_bad++; $display("FAIL %s north beat %0d: got %0d want %0d", tag, k, seen[k], 3 - k); end
    end
    n_cmp++;
    if (a_ready !== 1'b1 || w_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s stream entry: a_ready %b w_ready %b want 1 0", tag, a_ready, w_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (north !== 32'd0) begin n_bad++; $display("FAIL %s stream north: got %h want 0", tag, north); end
    stim = '{vec(1, 1, 1)};
    run_stream(tag, 20);
    n_cmp++;
    if (n_res != 1 || res_val[0] != 6) begin
      n_bad++; $display("FAIL %s single result: got %0d results first %0d want 1 of 6", tag, n_res, n_res ? res_val[0] : -1);
    end
    n_cmp++;
    if (n_res == 0 || done_at != res_at[0] + 1) begin
      n_bad++; $display("FAIL %s done timing: got cyc %0d want one after result", tag, done_at);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL %s idle after: busy %b done %b want 0 0", tag, busy, done); end
  endtask

  task automatic test_back_to_back;
    int want [4] = '{1, 2, 3, 12};
    start_job(4);
    load_w(3, 2, 1);
    stim = '{vec(1, 0, 0), vec(0, 1, 0), vec(0, 0, 1), vec(2, 2, 2)};
    run_stream("b2b", 30);
    n_cmp++;
    if (n_res != 4 || done_at < 0) begin n_bad++; $display("FAIL b2b count: got %0d results done %0d want 4", n_res, done_at); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (res_val[k] != want[k] || res_at[k] != res_at[0] + k) begin
          n_bad++; $display("FAIL b2b result %0d: got %0d at +%0d want %0d at +%0d", k, res_val[k], res_at[k] - res_at[0], want[k], k);
        end
      end
    end
  endtask

  task automatic test_bubble;
    start_job(2);
    load_w(3, 2, 1);
    stim = '{vec(1, 0, 0), '0, vec(0, 1, 0)};
    run_stream("bubble", 30);
    n_cmp++;
    if (n_res != 2 || res_at[1] - res_at[0] != 2 || done_at < 0) begin
      n_bad++; $display("FAIL bubble results: got %0d results spacing %0d want 2 spaced 2", n_res, n_res == 2 ? res_at[1] - res_at[0] : -1);
    end
  endtask

  task automatic test_w_gap;
    start_job(1);
    w_valid = 1; w_data = 5; w_m[2] = 5;
    @(negedge clk);
    w_valid = 0; w_data = 8'd99;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (north !== 32'd5 || w_ready !== 1'b1 || a_ready !== 1'b0) begin
        n_bad++; $display("FAIL wgap stall: north %0d w_ready %b a_ready %b want 5 1 0", north, w_ready, a_ready);
      end
    end
    w_valid = 1; w_data = 6; w_m[1] = 6;
    @(negedge clk);
    w_data = 7; w_m[0] = 7;
    @(negedge clk);
    w_valid = 0;
    n_cmp++;
    if (north !== 32'd7 || a_ready !== 1'b1 || w_ready !== 1'b0) begin
      n_bad++; $display("FAIL wgap stream entry: north %0d a_ready %b w_ready %b want 7 1 0", north, a_ready, w_ready);
    end
    start = 1; n_vec = 8'd9;
    @(negedge clk);
    start = 0;
    n_cmp++;
    if (busy !== 1'b1 || a_ready !== 1'b1 || w_ready !== 1'b0) begin
      n_bad++; $display("FAIL wgap start ignored: busy %b a_ready %b w_ready %b want 1 1 0", busy, a_ready, w_ready);
    end
    stim = '{vec(1, 1, 1)};
    run_stream("wgap", 20);
    n_cmp++;
    if (n_res != 1 || res_val[0] != 18 || done_at < 0) begin
      n_bad++; $display("FAIL wgap result: got %0d results done %0d want 1 of 18", n_res, done_at);
    end
  endtask

  task automatic test_zero;
    start_job(0);
    load_w(4, 5, 6);
    n_cmp++;
    if (done !== 1'b1 || a_ready !== 1'b0) begin n_bad++; $display("FAIL zero done: done %b a_ready %b want 1 0", done, a_ready); end
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || a_ready !== 1'b0) begin
        n_bad++; $display("FAIL zero after: done %b busy %b res_valid %b a_ready %b want 0", done, busy, res_valid, a_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    start_job(4);
    load_w(3, 2, 1);
    stim = '{vec(1, 1, 1), vec(2, 2, 2), vec(3, 3, 3), vec(4, 4, 4)};
    run_stream("mid", 2);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({w_ready, a_ready, res_valid, busy, done} !== 5'b0 || north !== 32'd0 || west !== '0 || res_data !== 32'd0) begin
      n_bad++; $display("FAIL mid async reset: flags %b north %h west %h res %h want 0", {w_ready, a_ready, res_valid, busy, done}, north, west, res_data);
    end
    @(posedge clk);
    #2 rst_n = 1;
    sb.delete();
    repeat (15) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL mid quiet: res_valid %b done %b busy %b want 0", res_valid, done, busy);
      end
    end
    test_single("after_reset");
  endtask

  task automatic test_max;
    start_job(255);
    load_w(1, 2, 3);
    stim.delete();
    for (int k = 0; k < 255; k++)
      stim.push_back(vec($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    run_stream("max", 400);
    n_cmp++;
    if (n_res != 255 || done_at < 0 || sb.size() != 0) begin
      n_bad++; $display("FAIL max job: got %0d results done %0d left %0d want 255", n_res, done_at, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_single("single");
    test_back_to_back;
    test_bubble;
    test_w_gap;
    test_zero;
    test_reset_mid;
    test_max;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
